// File: rtl/dram_refresh_gen_pkg.sv
// Shared definitions for the DRAM refresh generator.
//   ROW_W       : width of the refresh row address (128 rows)
//   PEND_W      : width of the pending-refresh counter
//   ref_state_t : refresh sequencer states
package dram_pkg;
  localparam int ROW_W  = 7;
  localparam int PEND_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRIVE = 2'd2,
    DONE  = 2'd3
  } ref_state_t;
endpackage

// File: rtl/dram_refresh_gen_if.sv
// Refresh generator <-> DRAM arbiter / FILL stage bundle.
//   refen  : refresh enable (arbiter side drives)
//   refack : one-cycle grant pulse (arbiter side drives)
//   refreq : refresh request (generator drives)
//   a      : refresh row address, a[0] = A_0 ... a[6] = A_6
//   enab   : FILL drive enable
//   pend   : pending-count status, pend[0] = PEND_0 ... pend[2] = PEND_2
// Handshake: refreq is held high until either a refack pulse is sampled
// (grant taken, refreq drops the next cycle) or refen is sampled low
// (request withdrawn). refack while refreq is low is ignored.
interface dram_refresh_gen_if;
  logic                       refen;
  logic                       refack;
  logic                       refreq;
  logic [dram_pkg::ROW_W-1:0]  a;
  logic                       enab;
  logic [dram_pkg::PEND_W-1:0] pend;

  modport master (
    input  refen, refack,
    output refreq, a, enab, pend
  );

  modport slave (
    output refen, refack,
    input  refreq, a, enab, pend
  );
endinterface

// File: rtl/dram_refresh_gen_timer.sv
// Free-running refresh interval timer.
//   clk  : system clock
//   rst  : asynchronous active-high reset (loads PERIOD-1)
//   en   : count enable; low freezes the timer
//   tick : high for the cycle in which the timer sits at 0 while enabled;
//          consecutive ticks are exactly PERIOD enabled clocks apart
module dram_refresh_timer #(
  parameter int PERIOD = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int TW = $clog2(PERIOD);
  localparam logic [TW-1:0] RELOAD = TW'(PERIOD - 1);

  logic [TW-1:0] timer;

  assign tick = en && (timer == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= RELOAD;
    end else if (en) begin
      timer <= (timer == '0) ? RELOAD : timer - 1'b1;
    end
  end
endmodule

// File: rtl/dram_refresh_gen.sv
// DRAM refresh generator: interval timer, saturating pending counter,
// request/grant sequencer and 7-bit refresh row counter for FILL.
//   clk       : system clock, all state on rising edge
//   rst       : asynchronous active-high reset
//   bus       : dram_refresh_gen_if.master (refen, refack in; refreq, a,
//               enab, pend out)
//   state_dbg : current sequencer state
// Build option: define REFRESH_BURST_EN to let one grant flush every
// pending row back-to-back (enab drops for one clock between rows).
module dram_refresh_gen
  import dram_pkg::*;
#(
  parameter int PERIOD   = 256,
  parameter int ENAB_CYC = 3,
  parameter int MAX_PEND = 3
) (
  input  logic               clk,
  input  logic               rst,
  dram_refresh_gen_if.master bus,
  output ref_state_t         state_dbg
);
  localparam int CNT_W = (ENAB_CYC > 1) ? $clog2(ENAB_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ENAB_CYC - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

`ifdef REFRESH_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  ref_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ROW_W-1:0]  row;
  logic [PEND_W-1:0] pend, pend_n;
  logic              refreq_q, enab_q;
  logic              tick;
  logic              row_done;

  dram_refresh_timer #(.PERIOD(PERIOD)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.refen),
    .tick (tick)
  );

  assign row_done = (state == DONE);

  // A tick and a completion in the same cycle cancel, even at saturation;
  // otherwise a tick at MAX_PEND is simply lost.
  always_comb begin
    pend_n = pend;
    if (row_done && !tick) begin
      pend_n = pend - 1'b1;
    end else if (!row_done && tick && (pend != PEND_MAX)) begin
      pend_n = pend + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if ((pend != '0) && bus.refen) state_n = REQ;
      end
      REQ: begin
        // A grant already issued wins over a same-cycle refen drop.
        if (bus.refack) begin
          state_n = DRIVE;
          cnt_n   = '0;
        end else if (!bus.refen) begin
          state_n = IDLE;
        end
      end
      DRIVE: begin
        // refen is deliberately not looked at: a started row always finishes.
        if (cnt == CNT_LAST) state_n = DONE;
        else                 cnt_n   = cnt + 1'b1;
      end
      DONE: begin
        state_n = IDLE;
        if (BURST && (pend_n != '0) && bus.refen) begin
          state_n = DRIVE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // refreq/enab are registered from the next state so they switch on the
  // same edge as the state itself and never glitch; they are mutually
  // exclusive because the state is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row      <= '0;
      pend     <= '0;
      refreq_q <= 1'b0;
      enab_q   <= 1'b0;
    end else begin
      pend     <= pend_n;
      refreq_q <= (state_n == REQ);
      enab_q   <= (state_n == DRIVE);
      if (row_done) row <= row + 1'b1;
    end
  end

  assign bus.refreq = refreq_q;
  assign bus.enab   = enab_q;
  assign bus.a      = row;
  assign bus.pend   = pend;
  assign state_dbg  = state;
endmodule

// File: tb/tb_dram_refresh_gen.sv
// Bench for dram_refresh_gen (PERIOD=16, ENAB_CYC=3, MAX_PEND=3).
// A reference model advances on every clock edge and pushes the expected
// {refreq, enab, a, pend} for the following cycle; a monitor pops and
// compares on every falling edge. Directed checks cover the first-request
// latency, refen withdrawal and asynchronous reset during a row.
module tb_dram_refresh_gen;
  import dram_pkg::*;

  localparam int PERIOD   = 16;
  localparam int ENAB_CYC = 3;
  localparam int MAX_PEND = 3;
  localparam int W        = 2 + ROW_W + PEND_W;

`ifdef REFRESH_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_refresh_gen_if bus ();
  ref_state_t dut_state;

  dram_refresh_gen #(
    .PERIOD   (PERIOD),
    .ENAB_CYC (ENAB_CYC),
    .MAX_PEND (MAX_PEND)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .state_dbg (dut_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Timing is expressed from the grant edge: enab is high for the ENAB_CYC
  // cycles following the grant, the row completes ENAB_CYC+1 edges after it.
  logic [W-1:0] exp_q[$];
  bit model_live = 1'b0;
  int k = 0;
  int en_clks, m_pend, m_row, t_grant;
  bit m_req;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      en_clks = 0; m_pend = 0; m_row = 0; t_grant = -1; m_req = 1'b0;
      exp_q.delete();
      exp_q.push_back('0);
      model_live = 1'b1;
    end else begin
      bit tick, completion, enab_exp;
      int new_pend;
      k++;
      tick = bus.refen && ((en_clks % PERIOD) == PERIOD - 1);
      if (bus.refen) en_clks++;
      completion = (t_grant >= 0) && (k - t_grant == ENAB_CYC + 1);
      new_pend = m_pend;
      if (completion && !tick) new_pend = m_pend - 1;
      else if (!completion && tick && m_pend < MAX_PEND) new_pend = m_pend + 1;

      if (m_req) begin
        if (bus.refack) begin
          t_grant = k;
          m_req   = 1'b0;
        end else if (!bus.refen) begin
          m_req = 1'b0;
        end
      end else if (t_grant < 0) begin
        if (m_pend > 0 && bus.refen) m_req = 1'b1;
      end else if (completion) begin
        m_row   = (m_row + 1) % 128;
        t_grant = (BURST && new_pend > 0 && bus.refen) ? k : -1;
      end
      m_pend   = new_pend;
      enab_exp = (t_grant >= 0) && (k - t_grant < ENAB_CYC);
      exp_q.push_back({m_req, enab_exp, ROW_W'(m_row), PEND_W'(m_pend)});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int mon_cyc = 0;
  int dut_enab_cnt = 0, exp_enab_cnt = 0;
  int dut_wraps = 0, exp_wraps = 0;
  logic [ROW_W-1:0] prev_a = '0, prev_exp_a = '0;

  always @(negedge clk) begin
    mon_cyc++;
    if (model_live) begin
      logic [W-1:0] e, got;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: cycle %0d got no expected entry, required one", mon_cyc);
      end else begin
        e   = exp_q.pop_front();
        got = {bus.refreq, bus.enab, bus.a, bus.pend};
        if (got !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got refreq=%0b enab=%0b a=%0d pend=%0d (state %s) expected refreq=%0b enab=%0b a=%0d pend=%0d",
                   mon_cyc, got[W-1], got[W-2], got[PEND_W +: ROW_W], got[PEND_W-1:0],
                   dut_state.name(), e[W-1], e[W-2], e[PEND_W +: ROW_W], e[PEND_W-1:0]);
        end
        if (bus.enab === 1'b1) dut_enab_cnt++;
        if (e[W-2]) exp_enab_cnt++;
        if (!rst && prev_a == 7'd127 && bus.a == 7'd0) dut_wraps++;
        if (!rst && prev_exp_a == 7'd127 && e[PEND_W +: ROW_W] == 7'd0) exp_wraps++;
        prev_a     = bus.a;
        prev_exp_a = e[PEND_W +: ROW_W];
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int first, drop_left;
    bus.refen  = 1'b0;
    bus.refack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    bus.refen = 1'b1;

    // First request: tick at edge 16, request visible after edge 17.
    first = 0;
    for (int c = 1; c <= 40 && first == 0; c++) begin
      @(posedge clk); #1;
      if (bus.refreq) first = c;
    end
    check("first_refreq_cycle", first, 17);
    // Let pend run into saturation with no grants.
    repeat (60) @(posedge clk);

    // Randomized arbiter with occasional refen drops and spurious grants.
    drop_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (drop_left > 0) begin
        drop_left--;
        bus.refen = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        drop_left = $urandom_range(0, 5);
        bus.refen = 1'b0;
      end else begin
        bus.refen = 1'b1;
      end
      if (bus.refreq) bus.refack = ($urandom_range(0, 2) == 0);
      else            bus.refack = ($urandom_range(0, 24) == 0);
    end

    // refen withdrawn while requesting.
    bus.refack = 1'b0;
    bus.refen  = 1'b1;
    first = 0;
    for (int c = 1; c <= 200 && first == 0; c++) begin
      @(posedge clk); #1;
      if (bus.refreq) first = c;
    end
    check("refreq_seen_before_withdraw", int'(first != 0), 1);
    bus.refen = 1'b0;
    @(posedge clk); #1;
    check("refreq_drops_after_refen_low", int'(bus.refreq), 0);
    repeat (5) @(posedge clk);
    #1 bus.refen = 1'b1;
    @(posedge clk); #1;
    check("refreq_reasserts_after_refen_high", int'(bus.refreq), 1);

    // Grant, then reset during the second enab cycle.
    bus.refack = 1'b1;
    @(posedge clk); #1;
    bus.refack = 1'b0;
    check("enab_after_grant", int'(bus.enab), 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("enab_async_reset", int'(bus.enab), 0);
    check("a_async_reset", int'(bus.a), 0);
    check("pend_async_reset", int'(bus.pend), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    first = 0;
    for (int c = 1; c <= 40 && first == 0; c++) begin
      @(posedge clk); #1;
      if (bus.pend != '0) first = c;
    end
    check("first_tick_after_reset", first, PERIOD);

    repeat (40) @(posedge clk);
    @(negedge clk); #1;
    check("enab_cycle_total", dut_enab_cnt, exp_enab_cnt);
    check("row_wrap_count", dut_wraps, exp_wraps);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
